bf_sdf_stage: RTL
=================

Name: bf_sdf_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage.
- Sits directly upstream of the twiddle multiplier. It supplies that multiplier's 9-bit signed x_r/x_i operands and a twiddle index for the twiddle ROM.
- Accepts one complex 8-bit sample per valid cycle. Holds the first half-frame in an internal delay line, then emits sums and differences.

Parameters:
- DEPTH, 16: half-frame length D (FFT size N = 2*D); power of two, 2..512.
- IW, 8: input component width, signed.
- OW, 9: output component width (IW+1), signed.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  sample present on in_r/in_i this cycle
- in_r  in  IW  real part, signed
- in_i  in  IW  imaginary part, signed
- out_valid  out  1  out_r/out_i/tw_idx valid
- out_r  out  OW  real result, signed, to multiplier x_r
- out_i  out  OW  imaginary result, signed, to multiplier x_i
- tw_idx  out  clog2(DEPTH)  twiddle index k (W_N^k) for this output
- frame_start  out  1  first output of a butterfly half-frame

Behaviour:
- Clock and reset: one clock clk; reset rstn is asynchronous, active-low.
- Reset values: out_valid=0, out_r=0, out_i=0, tw_idx=0, frame_start=0, cnt=0, primed=0. Delay-line contents are not cleared.
- cnt, range 0..2D-1:
  - Increments only on accepted samples (in_valid=1).
  - Wraps 2D-1 -> 0.
  - Phase A: cnt < D. Phase B: cnt >= D.
- Delay line:
  - D-entry FIFO of OW-bit complex words.
  - Advances exactly once per accepted sample. dl_out is the word written D accepted samples earlier.
- Phase A, per accepted sample x:
  - Write dl_in = sign-extend(x).
  - Registered output = dl_out, the difference from the previous frame.
  - tw_idx = cnt.
  - out_valid = primed.
- Phase B, per accepted sample x, with a = dl_out:
  - Registered output = a + x, full OW-bit, no overflow possible.
  - Write dl_in = a - x.
  - tw_idx = 0.
  - out_valid = 1.
- primed: set on the accepted sample with cnt=2D-1. Stays set until reset.
- Latency:
  - Sums appear 1 cycle after the accepted sample, i.e. D+1 accepted samples after a frame's first sample.
  - Differences appear 1 cycle after each accepted Phase A sample of the next frame.
- frame_start: 1 with the output for cnt=D (first sum), and with cnt=0 when primed (first difference).
- Stall (in_valid=0):
  - No state change.
  - out_valid=0 next cycle.
  - out_r/out_i/tw_idx hold their last values.
- Draining: the final frame's differences are pushed out by feeding D further samples (zeros permitted). No separate flush input.
- Reset mid-frame: cnt and primed return to 0. Partial-frame data is discarded and not emitted.
- Arithmetic: two's complement throughout; add/sub done at OW bits after sign extension of x.

Optional Feature:
- Macro: BF_SCALE_EN.
- Defined:
  - Every output is (value >>> 1), rounded half away from zero: add +1 before shift if value ≥ 0; add −1 (i.e., add 1 to magnitude) if negative.
  - Applies to both sums and differences, at output only. The delay line stores unscaled differences.
  - Output range stays within OW bits.
- Undefined: unscaled outputs as above.

Decomposition:
- Shared package fft_pkg:
  - Default IW/OW constants.
  - Complex sample struct typedef {re, im}.
  - clog2-based index width function.
  - Rounding helper constant/function shared with the multiplier's truncation convention.
- Sub-module sdf_delay_line (parameters DEPTH, W):
  - Circular RAM with single read/write pointer, advanced by an enable.
  - Read-before-write in the same cycle.
  - No reset on storage.

Test Plan:
All scenarios use DEPTH=4 unless noted.
- Basic frame:
  - Stimulus: in_r = 1,2,3,4,5,6,7,8 (in_i=0), continuous valid, then 4 zeros.
  - Required: sums 6,8,10,12 (tw_idx 0, frame_start on 6), then differences -4,-4,-4,-4 (tw_idx 0,1,2,3, frame_start on first).
- Extremes:
  - Stimulus: first half all -128, second half all -128.
  - Required: sums -256.
  - Stimulus: first half 127, second half -128.
  - Required: differences 255, no wrap; imaginary part checked identically.
- Stalls:
  - Stimulus: basic frame with in_valid low every other cycle.
  - Required: identical output sequence; out_valid=0 on the cycle after each gap; data holds.
- Unprimed:
  - Stimulus: the first 4 samples after reset.
  - Required: out_valid stays 0 during them. Then assert rstn=0 at cnt=6; after release, feed a new frame: no stale differences are emitted.
- BF_SCALE_EN:
  - Stimulus: first half 1,-2,127,-128 paired with 2,-1,127,-128.
  - Required: sums 3,-3,254,-256 -> 2,-2,127,-128; differences -1,-1,0,0 -> -1,-1,0,0.
- Random:
  - Stimulus: DEPTH=16, 1000 random frames with random stalls.
  - Required: matches a reference model of the radix-2 DIF first stage bit-exactly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, complex word type, index
// width helper and the round-half-away-from-zero halving used downstream.
package fft_pkg;

  localparam int IW_DEF = 8;
  localparam int OW_DEF = 9;

  typedef struct packed {
    logic signed [OW_DEF-1:0] re;
    logic signed [OW_DEF-1:0] im;
  } cplx_t;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Halve with rounding half away from zero, working on the magnitude.
  function automatic int rnd_shr1(input int v);
    return (v >= 0) ? ((v + 1) >>> 1) : -((-v + 1) >>> 1);
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Circular-RAM delay line of DEPTH words; one pointer serves read and write,
// so rd_data is the word written DEPTH enabled cycles ago.
module sdf_delay_line
  import fft_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 18,
  localparam int AW   = idx_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] ptr_q;

  assign rd_data = mem_q[ptr_q];

  always_ff @(posedge clk) begin
    if (en) mem_q[ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   ptr_q <= '0;
    else if (en) ptr_q <= ptr_q + AW'(1);
  end

endmodule

// File: rtl/bf_sdf_stage.sv
// Radix-2 SDF butterfly stage feeding the twiddle multiplier.
// Define BF_SCALE_EN to halve every output (round half away from zero).
module bf_sdf_stage
  import fft_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = IW_DEF,
  parameter int OW    = OW_DEF,
  localparam int KW   = idx_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic signed [IW-1:0] in_r,
  input  logic signed [IW-1:0] in_i,
  output logic                 out_valid,
  output logic signed [OW-1:0] out_r,
  output logic signed [OW-1:0] out_i,
  output logic [KW-1:0]        tw_idx,
  output logic                 frame_start
);

  localparam int CW = KW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * DEPTH - 1);

  function automatic logic signed [OW-1:0] scale_out(input logic signed [OW-1:0] v);
`ifdef BF_SCALE_EN
    int t;
    t = rnd_shr1(int'(v));
    return t[OW-1:0];
`else
    return v;
`endif
  endfunction

  logic [CW-1:0]        cnt_q;
  logic                 primed_q;
  logic                 vld_q;
  logic                 fs_q;
  logic [KW-1:0]        tw_q;
  logic signed [OW-1:0] re_q;
  logic signed [OW-1:0] im_q;

  logic                 phase_b;
  logic signed [OW-1:0] x_r, x_i, a_r, a_i;
  logic signed [OW-1:0] sum_r, sum_i, dif_r, dif_i;
  logic [2*OW-1:0]      dl_rd, dl_wr;

  assign phase_b = cnt_q[KW];
  assign x_r     = {{(OW-IW){in_r[IW-1]}}, in_r};
  assign x_i     = {{(OW-IW){in_i[IW-1]}}, in_i};
  assign a_r     = $signed(dl_rd[2*OW-1:OW]);
  assign a_i     = $signed(dl_rd[OW-1:0]);
  assign sum_r   = a_r + x_r;
  assign sum_i   = a_i + x_i;
  assign dif_r   = a_r - x_r;
  assign dif_i   = a_i - x_i;
  // Phase A parks the raw sample; phase B parks the difference for the next frame.
  assign dl_wr   = phase_b ? {dif_r, dif_i} : {x_r, x_i};

  sdf_delay_line #(.DEPTH(DEPTH), .W(2*OW)) u_dl (
    .clk     (clk),
    .rstn    (rstn),
    .en      (in_valid),
    .wr_data (dl_wr),
    .rd_data (dl_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
      vld_q    <= 1'b0;
      fs_q     <= 1'b0;
      tw_q     <= '0;
      re_q     <= '0;
      im_q     <= '0;
    end else begin
      vld_q <= 1'b0;
      fs_q  <= 1'b0;
      if (in_valid) begin
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) primed_q <= 1'b1;
        if (phase_b) begin
          re_q  <= scale_out(sum_r);
          im_q  <= scale_out(sum_i);
          tw_q  <= '0;
          vld_q <= 1'b1;
          fs_q  <= (cnt_q[KW-1:0] == '0);
        end else begin
          re_q  <= scale_out(a_r);
          im_q  <= scale_out(a_i);
          tw_q  <= cnt_q[KW-1:0];
          vld_q <= primed_q;
          fs_q  <= primed_q && (cnt_q[KW-1:0] == '0);
        end
      end
    end
  end

  assign out_valid   = vld_q;
  assign out_r       = re_q;
  assign out_i       = im_q;
  assign tw_idx      = tw_q;
  assign frame_start = fs_q;

endmodule
